clag_divider: RTL and testbench



---
 rtl/clag_pkg.sv | 17 +
 rtl/clag_sub.sv | 65 ++++++
 rtl/clag_divider.sv | 126 ++++++++++++
 tb/tb_clag_divider.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clag_pkg.sv
// Shared types and sizing helpers for the carry-lookahead divider.
package clag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned GROUP_W = 4;

  // Round a bit width up to the next whole lookahead group.
  function automatic int unsigned pad_width(input int unsigned w);
    return ((w + GROUP_W - 1) / GROUP_W) * GROUP_W;
  endfunction

endpackage

// File: rtl/clag_sub.sv
// Combinational N-bit subtractor (a - b) using 4-bit group P/G and
// a second-level lookahead across groups; no_borrow is the final carry-out.
module clag_sub
  import clag_pkg::*;
#(
  parameter int unsigned N = 12
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  localparam int unsigned NG = N / GROUP_W;

  logic [N-1:0]  bn;
  logic [N-1:0]  p;
  logic [N-1:0]  g;
  logic [NG-1:0] gp;
  logic [NG-1:0] gg;
  logic [NG:0]   gc;

  assign bn = ~b;
  assign p  = a ^ bn;
  assign g  = a & bn;

  // Carry into group k as a flat sum of products over group P/G and cin=1.
  function automatic logic group_carry(input logic [NG-1:0] gp_v,
                                       input logic [NG-1:0] gg_v,
                                       input int            k);
    logic c;
    logic prod;
    c = 1'b1;
    for (int m = 0; m < k; m++) c = c & gp_v[m];
    for (int j = 0; j < k; j++) begin
      prod = gg_v[j];
      for (int m = j + 1; m < k; m++) prod = prod & gp_v[m];
      c = c | prod;
    end
    return c;
  endfunction

  for (genvar k = 0; k < NG; k++) begin : g_grp
    localparam int unsigned BASE = k * GROUP_W;
    logic [GROUP_W-1:0] c;

    assign gp[k] = &p[BASE +: GROUP_W];
    assign gg[k] = g[BASE+3] | (p[BASE+3] & (g[BASE+2] | (p[BASE+2] &
                   (g[BASE+1] | (p[BASE+1] & g[BASE])))));

    assign c[0] = gc[k];
    for (genvar i = 1; i < GROUP_W; i++) begin : g_bit
      assign c[i] = g[BASE+i-1] | (p[BASE+i-1] & c[i-1]);
    end

    assign diff[BASE +: GROUP_W] = p[BASE +: GROUP_W] ^ c;
  end

  for (genvar k = 0; k <= NG; k++) begin : g_cla
    assign gc[k] = group_carry(gp, gg, k);
  end

  assign no_borrow = gc[NG];

endmodule

// File: rtl/clag_divider.sv
// Iterative unsigned restoring divider: one quotient bit per cycle through
// a lookahead subtractor, with valid/ready request and result ports.
module clag_divider
  import clag_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PAD_W = pad_width(WIDTH + 1);

  state_t             state;
  state_t             state_n;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   dvd;
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   prem;

  logic               accept_c;
  logic               last_c;
  logic [WIDTH:0]     trial_c;
  logic [PAD_W-1:0]   diff_c;
  logic               no_borrow_c;
  logic [WIDTH-1:0]   prem_n_c;
  logic [WIDTH-1:0]   dvd_n_c;
  logic               unused_hi;

  // Trial subtraction of the divisor from {partial remainder, next dividend bit}.
  assign trial_c = {prem, dvd[WIDTH-1]};

  clag_sub #(
    .N (PAD_W)
  ) u_sub (
    .a         (PAD_W'(trial_c)),
    .b         (PAD_W'(dvs)),
    .diff      (diff_c),
    .no_borrow (no_borrow_c)
  );

  assign unused_hi = ^diff_c[PAD_W-1:WIDTH];

  assign prem_n_c = no_borrow_c ? diff_c[WIDTH-1:0] : trial_c[WIDTH-1:0];
  // Quotient bits fill the dividend register from the bottom as it drains.
  assign dvd_n_c  = {dvd[WIDTH-2:0], no_borrow_c};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_n  = (divisor == '0) ? DONE : CALC;
        end
      end
      CALC: begin
        if (cnt == CNT_W'(1)) begin
          last_c  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      cnt         <= '0;
      dvd         <= '0;
      dvs         <= '0;
      prem        <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      in_ready  <= (state_n == IDLE);
      out_valid <= (state_n == DONE);
      if (accept_c) begin
        dvd  <= dividend;
        dvs  <= divisor;
        prem <= '0;
        if (divisor == '0) begin
          cnt         <= '0;
          quotient    <= '1;
          remainder   <= dividend;
          div_by_zero <= 1'b1;
        end else begin
          cnt <= CNT_W'(WIDTH);
        end
      end else if (state == CALC) begin
        prem <= prem_n_c;
        dvd  <= dvd_n_c;
        cnt  <= cnt - CNT_W'(1);
        if (last_c) begin
          quotient    <= dvd_n_c;
          remainder   <= prem_n_c;
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_clag_divider.sv
// Directed and randomized self-checking bench for clag_divider (WIDTH=8).
module tb_clag_divider;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] quotient;
  logic [7:0] remainder;
  logic       div_by_zero;

  int errors = 0;
  int checks = 0;

  clag_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, output bit ok);
    ok       = 1'b0;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL reset_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL reset_remainder got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_basic();
    bit ok;
    int n;
    send(8'd100, 8'd7, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL basic_accept got=%b exp=1", ok); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got=%b exp=0", out_valid); end
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL basic_latency got=%0d exp=8", n); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL basic_quotient got=%0d exp=14", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL basic_remainder got=%0d exp=2", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_dbz got=%b exp=0", div_by_zero); end
    handoff();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_idle_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [6] = '{8'd255, 8'd255, 8'd0, 8'd254, 8'd128, 8'd200};
    logic [7:0] vb [6] = '{8'd1,   8'd255, 8'd9, 8'd255, 8'd2,   8'd13};
    logic [7:0] vq [6] = '{8'd255, 8'd1,   8'd0, 8'd0,   8'd64,  8'd15};
    logic [7:0] vr [6] = '{8'd0,   8'd0,   8'd0, 8'd254, 8'd0,   8'd5};
    bit ok;
    int n;
    for (int i = 0; i < 6; i++) begin
      send(va[i], vb[i], ok);
      wait_valid(n);
      checks++; if (n != 8) begin errors++; $display("FAIL bound%0d_latency got=%0d exp=8", i, n); end
      checks++; if (quotient !== vq[i]) begin errors++; $display("FAIL bound%0d_quotient %0d/%0d got=%0d exp=%0d", i, va[i], vb[i], quotient, vq[i]); end
      checks++; if (remainder !== vr[i]) begin errors++; $display("FAIL bound%0d_remainder %0d/%0d got=%0d exp=%0d", i, va[i], vb[i], remainder, vr[i]); end
      checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL bound%0d_dbz got=%b exp=0", i, div_by_zero); end
      handoff();
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int n;
    send(8'd3, 8'd200, ok);
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL bp_latency got=%0d exp=8", n); end
    dividend = 8'd50;
    divisor  = 8'd5;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d_valid got=%b exp=1", i, out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold%0d_in_ready got=%b exp=0", i, in_ready); end
      checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL bp_hold%0d_quotient got=%0d exp=0", i, quotient); end
      checks++; if (remainder !== 8'd3) begin errors++; $display("FAIL bp_hold%0d_remainder got=%0d exp=3", i, remainder); end
    end
    in_valid = 1'b0;
    handoff();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid got=%b exp=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_div_zero();
    bit ok;
    int n;
    send(8'd5, 8'd0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL dz_accept got=%b exp=1", ok); end
    wait_valid(n);
    checks++; if (n != 0) begin errors++; $display("FAIL dz_latency got=%0d exp=0", n); end
    checks++; if (quotient !== 8'hFF) begin errors++; $display("FAIL dz_quotient got=%0d exp=255", quotient); end
    checks++; if (remainder !== 8'd5) begin errors++; $display("FAIL dz_remainder got=%0d exp=5", remainder); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_flag got=%b exp=1", div_by_zero); end
    handoff();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL dz_valid_drop got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    bit ok;
    int n;
    send(8'd100, 8'd7, ok);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (quotient !== 8'd0) begin errors++; $display("FAIL ar_quotient got=%0d exp=0", quotient); end
    checks++; if (remainder !== 8'd0) begin errors++; $display("FAIL ar_remainder got=%0d exp=0", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ar_dbz got=%b exp=0", div_by_zero); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got=%b exp=0", out_valid); end
    #3;
    rst_n = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_no_partial got=%b exp=0", out_valid); end
    end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_idle_ready got=%b exp=1", in_ready); end
    send(8'd100, 8'd7, ok);
    wait_valid(n);
    checks++; if (n != 8) begin errors++; $display("FAIL ar_latency got=%0d exp=8", n); end
    checks++; if (quotient !== 8'd14) begin errors++; $display("FAIL ar_quotient2 got=%0d exp=14", quotient); end
    checks++; if (remainder !== 8'd2) begin errors++; $display("FAIL ar_remainder2 got=%0d exp=2", remainder); end
    handoff();
  endtask

  task automatic test_back_to_back();
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] ea, eb, exq, exr;
    logic       exz;
    int sent = 0;
    int done = 0;
    int cyc  = 0;
    bit acc, hand;
    dividend = 8'($urandom_range(0, 255));
    divisor  = 8'($urandom_range(0, 255));
    in_valid = 1'b1;
    while (done < 1000 && cyc < 60000) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 1000);
      acc  = in_ready && (sent < 1000);
      hand = out_valid && out_ready;
      if (hand) begin
        if (qa.size() == 0) begin
          checks++; errors++;
          $display("FAIL b2b_extra_result got=%0d/%0d exp=none", quotient, remainder);
        end else begin
          ea = qa.pop_front();
          eb = qb.pop_front();
          exq = (eb == 8'd0) ? 8'hFF : ea / eb;
          exr = (eb == 8'd0) ? ea : ea % eb;
          exz = (eb == 8'd0);
          checks++; if (quotient !== exq) begin errors++; $display("FAIL b2b_quotient %0d/%0d got=%0d exp=%0d", ea, eb, quotient, exq); end
          checks++; if (remainder !== exr) begin errors++; $display("FAIL b2b_remainder %0d/%0d got=%0d exp=%0d", ea, eb, remainder, exr); end
          checks++; if (div_by_zero !== exz) begin errors++; $display("FAIL b2b_dbz %0d/%0d got=%b exp=%b", ea, eb, div_by_zero, exz); end
        end
        done++;
      end
      if (acc) begin
        qa.push_back(dividend);
        qb.push_back(divisor);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        dividend = 8'($urandom_range(0, 255));
        divisor  = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 15))
                                               : 8'($urandom_range(0, 255));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++; if (done != 1000) begin errors++; $display("FAIL b2b_count got=%0d exp=1000", done); end
    checks++; if (qa.size() != 0) begin errors++; $display("FAIL b2b_leftover got=%0d exp=0", qa.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_backpressure();
    test_div_zero();
    test_async_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
